bus_arbiter: RTL and testbench

BUS_ARBITER -- requirements
Module: bus_arbiter

---
 rtl/bus_arbiter.sv | 171 +++++++++++++++++
 tb/tb_bus_arbiter.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bus_arbiter.sv
// Two-master (instruction fetch / data) arbiter onto one shared memory port, one transaction in flight.
// Build option: define ARB_ROUND_ROBIN_EN for round-robin arbitration; otherwise data has fixed priority.
module bus_arbiter (
  input  logic        clk,
  input  logic        rst,

  input  logic        i_req_in,
  input  logic [31:0] i_addr_in,
  output logic        i_ready_out,
  output logic        i_valid_out,
  output logic [31:0] i_rdata_out,

  input  logic        d_req_in,
  input  logic [31:0] d_addr_in,
  input  logic [31:0] d_wdata_in,
  input  logic [3:0]  d_byte_en_in,
  output logic        d_ready_out,
  output logic        d_valid_out,
  output logic [31:0] d_rdata_out,

  input  logic        flush_in,

  output logic        bus_req_out,
  output logic [31:0] bus_addr_out,
  output logic [31:0] bus_wdata_out,
  output logic [3:0]  bus_byte_en_out,
  input  logic        bus_ready_in,
  input  logic        bus_valid_in,
  input  logic [31:0] bus_rdata_in,

  output logic        busy_out
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  localparam logic OWNER_I = 1'b0;
  localparam logic OWNER_D = 1'b1;

  state_t      r_state;
  logic        r_owner;
  logic        r_drop;
  logic        r_bus_req;
  logic [31:0] r_bus_addr;
  logic [31:0] r_bus_wdata;
  logic [3:0]  r_bus_be;
  logic        r_i_ready;
  logic        r_i_valid;
  logic [31:0] r_i_rdata;
  logic        r_d_ready;
  logic        r_d_valid;
  logic [31:0] r_d_rdata;
`ifdef ARB_ROUND_ROBIN_EN
  logic        r_rr_last_d;
`endif

  logic        w_i_pend;
  logic        w_grant_d;
  logic        w_grant_i;
  logic        w_owner_i_flush;

  // A fetch presented together with a flush is for a stale PC and must not win.
  assign w_i_pend = i_req_in && !flush_in;

`ifdef ARB_ROUND_ROBIN_EN
  assign w_grant_d = d_req_in && (!w_i_pend || !r_rr_last_d);
`else
  assign w_grant_d = d_req_in;
`endif
  assign w_grant_i = w_i_pend && !w_grant_d;

  assign w_owner_i_flush = flush_in && (r_owner == OWNER_I);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= ST_IDLE;
      r_owner     <= OWNER_I;
      r_drop      <= 1'b0;
      r_bus_req   <= 1'b0;
      r_bus_addr  <= 32'd0;
      r_bus_wdata <= 32'd0;
      r_bus_be    <= 4'd0;
      r_i_ready   <= 1'b0;
      r_i_valid   <= 1'b0;
      r_i_rdata   <= 32'd0;
      r_d_ready   <= 1'b0;
      r_d_valid   <= 1'b0;
      r_d_rdata   <= 32'd0;
`ifdef ARB_ROUND_ROBIN_EN
      r_rr_last_d <= 1'b0;
`endif
    end else begin
      r_i_ready <= 1'b0;
      r_i_valid <= 1'b0;
      r_d_ready <= 1'b0;
      r_d_valid <= 1'b0;

      case (r_state)
        ST_IDLE: begin
          if (w_grant_d || w_grant_i) begin
            r_owner     <= w_grant_d ? OWNER_D : OWNER_I;
            r_bus_addr  <= w_grant_d ? d_addr_in : i_addr_in;
            r_bus_wdata <= w_grant_d ? d_wdata_in : 32'd0;
            r_bus_be    <= w_grant_d ? d_byte_en_in : 4'd0;
            r_bus_req   <= 1'b1;
            r_drop      <= 1'b0;
            r_state     <= ST_REQ;
`ifdef ARB_ROUND_ROBIN_EN
            r_rr_last_d <= w_grant_d;
`endif
          end
        end

        ST_REQ: begin
          if (w_owner_i_flush) begin
            r_drop <= 1'b1;
          end
          if (bus_ready_in) begin
            r_bus_req <= 1'b0;
            if (r_owner == OWNER_D) begin
              r_d_ready <= 1'b1;
            end else begin
              r_i_ready <= 1'b1;
            end
            r_state <= ST_RESP;
          end
        end

        ST_RESP: begin
          if (w_owner_i_flush) begin
            r_drop <= 1'b1;
          end
          if (bus_valid_in) begin
            if (r_owner == OWNER_D) begin
              r_d_rdata <= bus_rdata_in;
              r_d_valid <= 1'b1;
            end else if (!(r_drop || flush_in)) begin
              r_i_rdata <= bus_rdata_in;
              r_i_valid <= 1'b1;
            end
            // Flag lifetime ends with the transaction; a later assignment wins over the set above.
            r_drop  <= 1'b0;
            r_state <= ST_IDLE;
          end
        end

        default: begin
          r_state   <= ST_IDLE;
          r_bus_req <= 1'b0;
          r_drop    <= 1'b0;
        end
      endcase
    end
  end

  assign i_ready_out     = r_i_ready;
  assign i_valid_out     = r_i_valid;
  assign i_rdata_out     = r_i_rdata;
  assign d_ready_out     = r_d_ready;
  assign d_valid_out     = r_d_valid;
  assign d_rdata_out     = r_d_rdata;
  assign bus_req_out     = r_bus_req;
  assign bus_addr_out    = r_bus_addr;
  assign bus_wdata_out   = r_bus_wdata;
  assign bus_byte_en_out = r_bus_be;
  assign busy_out        = (r_state != ST_IDLE);

endmodule

// File: tb/tb_bus_arbiter.sv
// Scoreboard bench for bus_arbiter: stimulus pushes expected pulses (kind, cycle, data); a negedge monitor pops and compares.
module tb_bus_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        i_req_in = 1'b0;
  logic [31:0] i_addr_in = '0;
  logic        i_ready_out, i_valid_out;
  logic [31:0] i_rdata_out;
  logic        d_req_in = 1'b0;
  logic [31:0] d_addr_in = '0;
  logic [31:0] d_wdata_in = '0;
  logic [3:0]  d_byte_en_in = '0;
  logic        d_ready_out, d_valid_out;
  logic [31:0] d_rdata_out;
  logic        flush_in = 1'b0;
  logic        bus_req_out;
  logic [31:0] bus_addr_out, bus_wdata_out;
  logic [3:0]  bus_byte_en_out;
  logic        bus_ready_in = 1'b0;
  logic        bus_valid_in = 1'b0;
  logic [31:0] bus_rdata_in = '0;
  logic        busy_out;

  bus_arbiter dut (
    .clk(clk), .rst(rst),
    .i_req_in(i_req_in), .i_addr_in(i_addr_in),
    .i_ready_out(i_ready_out), .i_valid_out(i_valid_out), .i_rdata_out(i_rdata_out),
    .d_req_in(d_req_in), .d_addr_in(d_addr_in), .d_wdata_in(d_wdata_in),
    .d_byte_en_in(d_byte_en_in),
    .d_ready_out(d_ready_out), .d_valid_out(d_valid_out), .d_rdata_out(d_rdata_out),
    .flush_in(flush_in),
    .bus_req_out(bus_req_out), .bus_addr_out(bus_addr_out), .bus_wdata_out(bus_wdata_out),
    .bus_byte_en_out(bus_byte_en_out),
    .bus_ready_in(bus_ready_in), .bus_valid_in(bus_valid_in), .bus_rdata_in(bus_rdata_in),
    .busy_out(busy_out)
  );

  always #5 clk = ~clk;

  localparam int K_I_READY = 0;
  localparam int K_I_VALID = 1;
  localparam int K_D_READY = 2;
  localparam int K_D_VALID = 3;

  typedef struct {
    int          kind;
    int          cyc;
    logic [31:0] data;
  } exp_t;

  exp_t        sb[$];
  int          cyc = 0;
  int          n_checks = 0;
  int          n_fail = 0;
  logic [31:0] m_i_rdata = 32'd0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic push(input int kind, input int c, input logic [31:0] data);
    exp_t e;
    e.kind = kind;
    e.cyc  = c;
    e.data = data;
    sb.push_back(e);
    if (kind == K_I_VALID) m_i_rdata = data;
  endtask

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic mon_pop(input int kind, input logic [31:0] data);
    exp_t e;
    n_checks++;
    if (sb.size() == 0) begin
      n_fail++;
      $display("FAIL sb_unexpected: got pulse kind %0d at cycle %0d, required no pulse", kind, cyc);
    end else begin
      e = sb.pop_front();
      if (e.kind != kind || e.cyc != cyc ||
          ((kind == K_I_VALID || kind == K_D_VALID) && e.data !== data)) begin
        n_fail++;
        $display("FAIL sb_pulse: got kind %0d cycle %0d data %08h, required kind %0d cycle %0d data %08h",
                 kind, cyc, data, e.kind, e.cyc, e.data);
      end else begin
        $display("txn kind=%0d cycle=%0d data=%08h", kind, cyc, data);
      end
    end
  endtask

  always @(negedge clk) begin
    if (rst) begin
      if (i_ready_out || i_valid_out || d_ready_out || d_valid_out) begin
        n_checks++;
        if ($countones({i_ready_out, i_valid_out, d_ready_out, d_valid_out}) > 1) begin
          n_fail++;
          $display("FAIL pulse_exclusive: got %b, required at most one high",
                   {i_ready_out, i_valid_out, d_ready_out, d_valid_out});
        end
      end
      if (i_ready_out) mon_pop(K_I_READY, 32'd0);
      if (i_valid_out) mon_pop(K_I_VALID, i_rdata_out);
      if (d_ready_out) mon_pop(K_D_READY, 32'd0);
      if (d_valid_out) mon_pop(K_D_VALID, d_rdata_out);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string name);
    check(name, {bus_req_out, i_ready_out, i_valid_out, d_ready_out, d_valid_out, busy_out,
                 bus_byte_en_out, bus_addr_out, bus_wdata_out},
          '0);
    check({name, "_rdata"}, {i_rdata_out, d_rdata_out}, '0);
  endtask

  // Plain fetch with minimum latency; returns with the bench in cycle N+3.
  task automatic fetch_min(input logic [31:0] addr, input logic [31:0] data);
    int n;
    n = cyc;
    i_req_in  = 1'b1;
    i_addr_in = addr;
    push(K_I_READY, n + 2, 32'd0);
    push(K_I_VALID, n + 3, data);
    tick();
    check("fetch_bus_req", {bus_req_out, bus_addr_out, bus_byte_en_out, busy_out}, {1'b1, addr, 4'h0, 1'b1});
    bus_ready_in = 1'b1;
    tick();
    check("fetch_req_drop", bus_req_out, 1'b0);
    bus_ready_in = 1'b0;
    i_req_in     = 1'b0;
    bus_valid_in = 1'b1;
    bus_rdata_in = data;
    tick();
    bus_valid_in = 1'b0;
    check("fetch_idle", {busy_out, i_rdata_out}, {1'b0, data});
  endtask

  int          order[3];
  logic [31:0] win_addr;
  int          n;

  initial begin
`ifdef ARB_ROUND_ROBIN_EN
    order = '{K_D_READY, K_I_READY, K_D_READY};
`else
    order = '{K_D_READY, K_D_READY, K_D_READY};
`endif
    #2;
    check_all_zero("reset_state");
    tick();
    tick();
    rst = 1'b1;
    tick();

    // Scenario 1: single fetch at minimum latency.
    fetch_min(32'h0000_0100, 32'h0000_0013);
    tick();

    // Scenario 3 (run while the arbiter last served fetch): both requesting, three back-to-back.
    n = cyc;
    i_req_in     = 1'b1;
    i_addr_in    = 32'h0000_0300;
    d_req_in     = 1'b1;
    d_addr_in    = 32'h0000_0400;
    d_byte_en_in = 4'h0;
    for (int k = 0; k < 3; k++) begin
      push(order[k], n + 3 * k + 2, 32'd0);
      push(order[k] + 1, n + 3 * k + 3, 32'h1111_0000 + k);
      win_addr = (order[k] == K_D_READY) ? 32'h0000_0400 : 32'h0000_0300;
      tick();
      check("arb_winner_addr", {bus_req_out, bus_addr_out, bus_byte_en_out}, {1'b1, win_addr, 4'h0});
      bus_ready_in = 1'b1;
      tick();
      bus_ready_in = 1'b0;
      bus_valid_in = 1'b1;
      bus_rdata_in = 32'h1111_0000 + k;
      if (k == 2) begin
        i_req_in = 1'b0;
        d_req_in = 1'b0;
      end
      tick();
      bus_valid_in = 1'b0;
    end
    check("arb_done_idle", busy_out, 1'b0);

    // Stray bus handshakes while idle must not create pulses or a transaction.
    bus_ready_in = 1'b1;
    bus_valid_in = 1'b1;
    tick();
    bus_ready_in = 1'b0;
    bus_valid_in = 1'b0;
    check("idle_stray_bus", {busy_out, bus_req_out}, 2'b00);

    // Scenario 2: store, bus_ready_in three cycles late.
    n = cyc;
    d_req_in     = 1'b1;
    d_addr_in    = 32'h0000_0200;
    d_wdata_in   = 32'hDEAD_BEEF;
    d_byte_en_in = 4'hF;
    push(K_D_READY, n + 5, 32'd0);
    push(K_D_VALID, n + 6, 32'h5A5A_5A5A);
    for (int j = 1; j <= 4; j++) begin
      tick();
      bus_valid_in = (j == 2);
      check("store_fields_stable", {bus_req_out, bus_addr_out, bus_wdata_out, bus_byte_en_out},
            {1'b1, 32'h0000_0200, 32'hDEAD_BEEF, 4'hF});
    end
    bus_valid_in = 1'b0;
    bus_ready_in = 1'b1;
    tick();
    bus_ready_in = 1'b0;
    d_req_in     = 1'b0;
    d_byte_en_in = 4'h0;
    check("store_req_drop", bus_req_out, 1'b0);
    bus_valid_in = 1'b1;
    bus_rdata_in = 32'h5A5A_5A5A;
    tick();
    bus_valid_in = 1'b0;
    check("store_idle", busy_out, 1'b0);
    tick();

    // Scenario 4: flush during fetch RESP, then a flushed-idle fetch, then a normal fetch.
    n = cyc;
    i_req_in  = 1'b1;
    i_addr_in = 32'h0000_0500;
    push(K_I_READY, n + 2, 32'd0);
    tick();
    bus_ready_in = 1'b1;
    tick();
    bus_ready_in = 1'b0;
    i_req_in     = 1'b0;
    flush_in     = 1'b1;
    tick();
    flush_in     = 1'b0;
    bus_valid_in = 1'b1;
    bus_rdata_in = 32'hBAD0_BAD0;
    tick();
    bus_valid_in = 1'b0;
    check("flush_rdata_kept", {busy_out, i_rdata_out}, {1'b0, m_i_rdata});
    i_req_in  = 1'b1;
    i_addr_in = 32'h0000_0104;
    flush_in  = 1'b1;
    tick();
    flush_in = 1'b0;
    check("flush_blocks_grant", {bus_req_out, busy_out}, 2'b00);
    fetch_min(32'h0000_0104, 32'h0010_0093);
    tick();

    // Scenario 5: reset asserted while in RESP.
    n = cyc;
    d_req_in  = 1'b1;
    d_addr_in = 32'h0000_0600;
    push(K_D_READY, n + 2, 32'd0);
    tick();
    bus_ready_in = 1'b1;
    tick();
    bus_ready_in = 1'b0;
    d_req_in     = 1'b0;
    @(negedge clk);
    #1;
    rst = 1'b0;
    #1;
    check_all_zero("reset_in_resp");
    tick();
    rst = 1'b1;
    bus_valid_in = 1'b1;
    bus_rdata_in = 32'hCAFE_F00D;
    tick();
    bus_valid_in = 1'b0;
    check("late_valid_ignored", {busy_out, bus_req_out, d_rdata_out}, {1'b0, 1'b0, 32'd0});
    tick();
    tick();

    n_checks++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL sb_leftover: got %0d pending expectations, required 0", sb.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout at cycle %0d, required test end", cyc);
    $fatal(1, "watchdog");
  end

endmodule
